// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a valid/ready handshake on both sides.
// Single-cycle logic/arith/shift ops, plus iterative MUL, DIVU and REMU
// that each take WIDTH cycles in BUSY.
// Optional feature: define SEQ_ALU_ROTATE_EN to enable opcode 1110 = ROTL.
module seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] source_A,
  input  logic [WIDTH-1:0] source_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned SHW      = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);
`ifdef SEQ_ALU_ROTATE_EN
  localparam logic [SHW:0] SH_FULL  = (SHW+1)'(WIDTH);
`endif

  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] opa_r;   // MUL: shifted multiplicand; DIV: dividend/quotient
  logic [WIDTH-1:0] opb_r;   // MUL: shifted multiplier;   DIV: divisor
  logic [WIDTH-1:0] acc_r;   // MUL partial product
  logic [WIDTH-1:0] rem_r;   // DIV partial remainder
  logic [SHW:0]     cnt_r;

  logic [SHW-1:0]   sh_c;
  logic [WIDTH-1:0] alu_c;
  logic             multi_c;
  logic [WIDTH-1:0] mul_acc_c;
  logic [WIDTH:0]   div_trial_c;
  logic             div_ge_c;
  logic [WIDTH-1:0] div_rem_c;
  logic [WIDTH-1:0] div_quo_c;
  logic [WIDTH-1:0] mc_res_c;

  assign sh_c    = source_B[SHW-1:0];
  assign multi_c = (control == OP_MUL) || (control == OP_DIVU) || (control == OP_REMU);

  // Single-cycle result computed straight from the presented operands
  always_comb begin
    alu_c = '0;
    case (control)
      4'b0000: alu_c = source_A & source_B;
      4'b0001: alu_c = source_A | source_B;
      4'b0010: alu_c = source_A + source_B;
      4'b0011: alu_c = source_A ^ source_B;
      4'b0100: alu_c = ~(source_A | source_B);
      4'b0101: alu_c = ~(source_A & source_B);
      4'b0110: alu_c = source_A - source_B;
      4'b0111: alu_c = WIDTH'($signed(source_A) < $signed(source_B));
      4'b1000: alu_c = WIDTH'(source_A < source_B);
      4'b1100: alu_c = source_A << sh_c;
      4'b1101: alu_c = source_A >> sh_c;
      4'b1111: alu_c = WIDTH'($signed(source_A) >>> sh_c);
`ifdef SEQ_ALU_ROTATE_EN
      // sh = 0 shifts right by WIDTH, which yields 0, so A passes through
      4'b1110: alu_c = (source_A << sh_c) | (source_A >> (SH_FULL - {1'b0, sh_c}));
`endif
      default: alu_c = '0;
    endcase
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    mul_acc_c   = opb_r[0] ? (acc_r + opa_r) : acc_r;
    div_trial_c = {rem_r, opa_r[WIDTH-1]};
    div_ge_c    = (div_trial_c >= {1'b0, opb_r});
    div_rem_c   = div_ge_c ? WIDTH'(div_trial_c - {1'b0, opb_r}) : div_trial_c[WIDTH-1:0];
    div_quo_c   = {opa_r[WIDTH-2:0], div_ge_c};
    case (op_r)
      OP_MUL:  mc_res_c = mul_acc_c;
      OP_DIVU: mc_res_c = div_quo_c;
      OP_REMU: mc_res_c = div_rem_c;
      default: mc_res_c = '0;
    endcase
  end

  // Control FSM, iterative datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      op_r      <= '0;
      opa_r     <= '0;
      opb_r     <= '0;
      acc_r     <= '0;
      rem_r     <= '0;
      cnt_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r     <= control;
            opa_r    <= source_A;
            opb_r    <= source_B;
            acc_r    <= '0;
            rem_r    <= '0;
            cnt_r    <= '0;
            in_ready <= 1'b0;
            if (multi_c) begin
              state <= BUSY;
              busy  <= 1'b1;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= alu_c;
              zero      <= (alu_c == '0);
            end
          end
        end
        BUSY: begin
          acc_r <= mul_acc_c;
          rem_r <= div_rem_c;
          if (op_r == OP_MUL) begin
            opa_r <= opa_r << 1;
            opb_r <= opb_r >> 1;
          end else begin
            opa_r <= div_quo_c;
          end
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            result    <= mc_res_c;
            zero      <= (mc_res_c == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a driver pushes expected responses from an
// arithmetic reference model, a monitor pops them when out_valid rises.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  control = '0;
  logic [31:0] source_A = '0;
  logic [31:0] source_B = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [3:0]  control8 = '0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        out_valid8;
  logic        out_ready8 = 1'b1;
  logic [7:0]  result8;
  logic        zero8;
  logic        busy8;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .control(control), .source_A(source_A), .source_B(source_B),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .busy(busy)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .control(control8), .source_A(a8), .source_B(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
    .zero(zero8), .busy(busy8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          lat;
    int          bcnt;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   rdy_rand = 1'b0;
  bit   rdy_val = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: random backpressure or a held level, changed just after the edge
  always @(posedge clk) begin
    #1;
    out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : rdy_val;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] r;
    logic [63:0] p;
    int unsigned sh;
    sh = int'(b % 32);
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a ^ b;
      4'd4:  r = ~(a | b);
      4'd5:  r = ~(a & b);
      4'd6:  r = a + (~b) + 32'd1;
      4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  r = (a < b) ? 32'd1 : 32'd0;
      4'd9:  begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      4'd10: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd11: r = (b == 0) ? a : a % b;
      4'd12: r = a << sh;
      4'd13: r = a >> sh;
      4'd15: begin
        r = a >> sh;
        if (a[31]) for (int i = 0; i < 32; i++) if (i >= 32 - int'(sh)) r[i] = 1'b1;
      end
`ifdef SEQ_ALU_ROTATE_EN
      4'd14: r = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
`endif
      default: r = 32'd0;
    endcase
    e.res  = r;
    e.z    = (r == 32'd0);
    e.lat  = (op == 4'd9 || op == 4'd10 || op == 4'd11) ? 33 : 1;
    e.bcnt = (op == 4'd9 || op == 4'd10 || op == 4'd11) ? 32 : 0;
    e.acc_cyc = 0;
    return e;
  endfunction

  // Monitor: compares on each new output, checks holding under backpressure
  bit          prev_ov = 1'b0;
  int          bcnt = 0;
  logic [31:0] held_res;
  logic        held_z;
  always @(negedge clk) begin
    if (reset) begin
      prev_ov = 1'b0;
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      if (out_valid) begin
        chk("in_ready_low_in_done", in_ready, 1'b0);
        if (!prev_ov) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 1'b1, 1'b0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("result", result, e.res);
            chk("zero", zero, e.z);
            chk("latency", cyc - e.acc_cyc, e.lat);
            chk("busy_cycles", bcnt, e.bcnt);
          end
          held_res = result;
          held_z = zero;
          bcnt = 0;
        end else begin
          chk("result_held", result, held_res);
          chk("zero_held", zero, held_z);
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("issue_timeout", 1'b1, 1'b0);
      return;
    end
    control = op; source_A = a; source_B = b; in_valid = 1'b1;
    e = model(op, a, b);
    e.acc_cyc = cyc;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    control = $urandom(); source_A = $urandom(); source_B = $urandom();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size() != 0, 1'b0);
  endtask

  task automatic run8(input string name, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp);
    int n;
    @(negedge clk);
    control8 = op; a8 = a; b8 = b; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, {out_valid8, result8}, {1'b1, exp});
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", zero, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);

    // Directed cases from the test plan
    issue(4'd2, 32'hFFFF_FFFF, 32'd1);
    issue(4'd6, 32'd3, 32'd5);
    issue(4'd9, 32'h0001_0003, 32'h0000_0005);
    issue(4'd10, 32'd100, 32'd7);
    issue(4'd11, 32'd100, 32'd7);
    issue(4'd10, 32'd9, 32'd0);
    issue(4'd11, 32'd9, 32'd0);
    issue(4'd14, 32'h8000_0001, 32'd1);
    drain();

    // Backpressure: SRA result held for 5 cycles with out_ready low
    rdy_val = 1'b0;
    @(negedge clk);
    issue(4'd15, 32'h8000_0000, 32'd31);
    repeat (5) @(negedge clk);
    chk("bp_valid_held", out_valid, 1'b1);
    chk("bp_result", result, 32'hFFFF_FFFF);
    chk("bp_in_ready", in_ready, 1'b0);
    rdy_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready_before_take", in_ready, 1'b0);
    @(negedge clk);
    chk("bp_in_ready_after_take", in_ready, 1'b1);

    // Reset during a MUL: no result may surface afterwards
    issue(4'd9, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1'b1);
    begin
      bit seen;
      seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      chk("abort_no_stale", seen, 1'b0);
    end

    // Randomized traffic with random backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand());
    end
    drain();
    rdy_rand = 1'b0;
    rdy_val = 1'b1;

    // Narrow instance
    run8("w8_slt", 4'd7, 8'h80, 8'h01, 8'h01);
    run8("w8_sltu", 4'd8, 8'h80, 8'h01, 8'h00);
    run8("w8_add", 4'd2, 8'hFF, 8'h02, 8'h01);
    run8("w8_mul", 4'd9, 8'h13, 8'h0B, 8'hD1);
    run8("w8_divu", 4'd10, 8'hC8, 8'h0D, 8'h0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational datapath ALU; adds iterative multiply, unsigned divide and remainder.
- Uses valid/ready handshakes on input and output, so the core can stall on multi-cycle ops.
- Sits between the register-read stage and writeback of the crypto processor core.
- Keeps the existing 4-bit control encoding; the free codes carry the new ops.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/control valid.
- in_ready  out  1  block can accept an op.
- control  in  4  opcode.
- source_A  in  WIDTH  operand A.
- source_B  in  WIDTH  operand B.
- out_valid  out  1  result/zero valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- zero  out  1  registered (result == 0).
- busy  out  1  multi-cycle op in progress.

Behaviour:
- Reset (async, active-high):
  - state = IDLE; out_valid = 0; result = 0; zero = 0; busy = 0; internal counter/accumulators = 0.
  - in_ready is 1 once reset deasserts.
- States: IDLE, BUSY, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
  - busy = (state == BUSY).
- Accept: in_valid && in_ready at a rising edge; control, source_A and source_B are captured internally.
- Single-cycle ops: IDLE -> DONE; out_valid is high one cycle after the accept edge.
  - 0000 AND, 0001 OR, 0010 ADD (mod 2^WIDTH), 0011 XOR, 0100 NOR, 0101 NAND.
  - 0110 SUB (two's complement, mod 2^WIDTH).
  - 0111 SLT signed -> 1/0.
  - 1000 SLTU unsigned -> 1/0.
  - 1100 SLL, 1101 SRL, 1111 SRA; shift amount = source_B[SHW-1:0].
  - Undefined codes -> result 0.
- Multi-cycle ops: IDLE -> BUSY for exactly WIDTH cycles -> DONE; out_valid is high WIDTH+1 cycles after the accept edge.
  - 1001 MUL: unsigned shift-add, one bit of B per cycle; result = low WIDTH bits of A*B.
  - 1010 DIVU: restoring division, one quotient bit per cycle; result = quotient.
  - 1011 REMU: same datapath; result = remainder.
  - Divide by zero still takes WIDTH cycles; DIVU -> all ones, REMU -> source_A.
- DONE:
  - result and zero are held stable while out_ready = 0.
  - out_valid && out_ready at an edge -> IDLE; in_ready is high the next cycle.
  - No accept in DONE, so peak throughput is one single-cycle op every 2 cycles.
- Input changes while not in IDLE are ignored.
- zero is updated in the same edge as result; it is meaningful only when out_valid = 1.
- Reset mid-op (BUSY or DONE): aborts immediately, state = IDLE, no result is issued.
- Counter width is SHW+1 bits; it terminates after WIDTH iterations with no wrap.

Optional Feature:
- Macro: SEQ_ALU_ROTATE_EN.
- Defined: opcode 1110 = ROTL, single-cycle. Result = (A << sh) | (A >> (WIDTH - sh)), sh = source_B[SHW-1:0]; sh = 0 returns A.
- Undefined: opcode 1110 is treated as undefined, giving result 0 and zero 1, single-cycle.

Test Plan:
- Reset mid-stream: assert reset during BUSY of MUL -> out_valid 0, in_ready 1 after release, no stale result appears.
- WIDTH=32, ADD A=0xFFFFFFFF, B=1, out_ready=1 -> out_valid one cycle after accept, result 0x00000000, zero 1. Same bench with SUB A=3, B=5 -> 0xFFFFFFFE, zero 0.
- WIDTH=32, MUL A=0x0001_0003, B=0x0000_0005 -> out_valid 33 cycles after accept, result 0x0005_000F, busy high for exactly 32 cycles.
- DIVU A=100, B=7 -> 14; REMU A=100, B=7 -> 2. DIVU A=9, B=0 -> 0xFFFFFFFF; REMU A=9, B=0 -> 9.
- Backpressure: SRA A=0x80000000, B=31 with out_ready=0 for 5 cycles -> result 0xFFFFFFFF held, in_ready 0 throughout; in_ready 1 the cycle after out_ready rises.
- Opcode 1110, A=0x80000001, B=1 -> result 0x00000003 with SEQ_ALU_ROTATE_EN; result 0, zero 1 without it. Repeat at WIDTH=8: SLT A=0x80, B=0x01 -> 1; SLTU A=0x80, B=0x01 -> 0.
